// File: rtl/pipe_stage_fifo.sv
`timescale 1ns/1ps
// Elastic DEPTH-entry buffer between pipeline stages. A pipeline flush discards its contents and counts the dropped beats.
// Latency: a push at edge N shows on out_* in cycle N+1. There is no bypass path.
// Backpressure: in_ready_o comes only from the registered occupancy and flush_i. It drops once DEPTH beats are held.
module pipe_stage_fifo #(
    parameter int   DATA_W = 96,
    parameter int   DEPTH  = 2,
    localparam int  CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [15:0]       drop_cnt_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       drop_q, drop_d;

    logic              not_empty;
    logic              push;
    logic              pop;
    logic [16:0]       drop_sum;

    assign not_empty   = (cnt_q != '0);
    assign in_ready_o  = (cnt_q != CNT_FULL) | flush_i;
    assign out_valid_o = not_empty & ~flush_i;
    assign out_data_o  = not_empty ? mem_q[rd_ptr_q] : '0;
    assign count_o     = cnt_q;
    assign drop_cnt_o  = drop_q;

    // A flush accepts the incoming beat but never stores it.
    assign push = in_valid_i & in_ready_o & ~flush_i;
    assign pop  = out_valid_o & out_ready_i;

    // Resident entries plus the incoming beat. The 17th bit detects overflow for saturation.
    assign drop_sum = {1'b0, drop_q} + 17'(cnt_q) + 17'(in_valid_i);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end else begin
            if (push) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[wr_ptr_q] = in_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
        end
    end

    // The payload array has no reset. out_data_o is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
`timescale 1ns/1ps
// Directed vectors for a DEPTH=2 and a DEPTH=3 instance, plus hand-written multi-cycle sequences.
module tb_pipe_stage_fifo;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic          a_fl, a_vld, a_ordy;
    logic [DW-1:0] a_dat;
    logic          a_irdy, a_ovld;
    logic [DW-1:0] a_odat;
    logic [1:0]    a_cnt;
    logic [15:0]   a_drop;

    // DEPTH=3 instance
    logic          b_fl, b_vld, b_ordy;
    logic [DW-1:0] b_dat;
    logic          b_irdy, b_ovld;
    logic [DW-1:0] b_odat;
    logic [1:0]    b_cnt;
    logic [15:0]   b_drop;

    pipe_stage_fifo #(.DATA_W(DW), .DEPTH(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flush_i(a_fl),
        .in_valid_i(a_vld), .in_ready_o(a_irdy), .in_data_i(a_dat),
        .out_valid_o(a_ovld), .out_ready_i(a_ordy), .out_data_o(a_odat),
        .count_o(a_cnt), .drop_cnt_o(a_drop)
    );

    pipe_stage_fifo #(.DATA_W(DW), .DEPTH(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .flush_i(b_fl),
        .in_valid_i(b_vld), .in_ready_o(b_irdy), .in_data_i(b_dat),
        .out_valid_o(b_ovld), .out_ready_i(b_ordy), .out_data_o(b_odat),
        .count_o(b_cnt), .drop_cnt_o(b_drop)
    );

    typedef struct {
        bit          sel;     // 0: DEPTH=2, 1: DEPTH=3
        bit          vld;
        bit [15:0]   dat;
        bit          ordy;
        bit          fl;
        bit          e_irdy;
        bit          e_ovld;
        bit [15:0]   e_odat;
        bit [1:0]    e_cnt;
        bit [15:0]   e_drop;
    } vec_t;

    vec_t vq[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add(input bit sel, input bit vld, input bit [15:0] dat, input bit ordy,
                       input bit fl, input bit e_irdy, input bit e_ovld,
                       input bit [15:0] e_odat, input bit [1:0] e_cnt, input bit [15:0] e_drop);
        vec_t v;
        v.sel = sel; v.vld = vld; v.dat = dat; v.ordy = ordy; v.fl = fl;
        v.e_irdy = e_irdy; v.e_ovld = e_ovld; v.e_odat = e_odat;
        v.e_cnt = e_cnt; v.e_drop = e_drop;
        vq.push_back(v);
    endtask

    task automatic idle_all();
        a_fl = 0; a_vld = 0; a_ordy = 0; a_dat = '0;
        b_fl = 0; b_vld = 0; b_ordy = 0; b_dat = '0;
    endtask

    initial begin
        idle_all();

        // DEPTH=2: stream 1..8 with out_ready high, one cycle of latency, count stays at 1
        add(0, 1, 16'h1, 1, 0, 1, 0, 16'h0, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            add(0, 1, 16'(k + 1), 1, 0, 1, 1, 16'(k), 1, 0);
        end
        add(0, 0, 16'h0, 1, 0, 1, 1, 16'h8, 1, 0);
        add(0, 0, 16'h0, 1, 0, 1, 0, 16'h0, 0, 0);
        // DEPTH=2: backpressure fills the buffer, then a flush with an incoming beat drops 3
        add(0, 1, 16'h11, 0, 0, 1, 0, 16'h0,  0, 0);
        add(0, 1, 16'h22, 0, 0, 1, 1, 16'h11, 1, 0);
        add(0, 1, 16'h33, 0, 0, 0, 1, 16'h11, 2, 0);
        add(0, 1, 16'h33, 0, 1, 1, 0, 16'h11, 2, 0);
        add(0, 1, 16'h44, 1, 0, 1, 0, 16'h0,  0, 3);
        add(0, 0, 16'h0,  1, 0, 1, 1, 16'h44, 1, 3);
        add(0, 0, 16'h0,  1, 0, 1, 0, 16'h0,  0, 3);
        // DEPTH=3: full at 3 with 0xD held, then drain across the write-pointer wrap
        add(1, 1, 16'hA, 0, 0, 1, 0, 16'h0, 0, 0);
        add(1, 1, 16'hB, 0, 0, 1, 1, 16'hA, 1, 0);
        add(1, 1, 16'hC, 0, 0, 1, 1, 16'hA, 2, 0);
        add(1, 1, 16'hD, 0, 0, 0, 1, 16'hA, 3, 0);
        add(1, 1, 16'hD, 1, 0, 0, 1, 16'hA, 3, 0);
        add(1, 1, 16'hD, 1, 0, 1, 1, 16'hB, 2, 0);
        add(1, 0, 16'h0, 1, 0, 1, 1, 16'hC, 2, 0);
        add(1, 0, 16'h0, 1, 0, 1, 1, 16'hD, 1, 0);
        add(1, 0, 16'h0, 1, 0, 1, 0, 16'h0, 0, 0);

        // Reset state while rst_n is held low
        #2;
        chk("rst_irdy", a_irdy, 1); chk("rst_ovld", a_ovld, 0);
        chk("rst_odat", a_odat, 0); chk("rst_cnt", a_cnt, 0);
        chk("rst_drop", a_drop, 0); chk("rst3_irdy", b_irdy, 1);
        @(negedge clk);
        rst_n = 1;

        foreach (vq[i]) begin
            @(negedge clk);
            idle_all();
            if (vq[i].sel == 0) begin
                a_vld = vq[i].vld; a_dat = vq[i].dat; a_ordy = vq[i].ordy; a_fl = vq[i].fl;
                #1;
                chk($sformatf("v%0d_irdy", i), a_irdy, vq[i].e_irdy);
                chk($sformatf("v%0d_ovld", i), a_ovld, vq[i].e_ovld);
                chk($sformatf("v%0d_odat", i), a_odat, vq[i].e_odat);
                chk($sformatf("v%0d_cnt", i),  a_cnt,  vq[i].e_cnt);
                chk($sformatf("v%0d_drop", i), a_drop, vq[i].e_drop);
            end else begin
                b_vld = vq[i].vld; b_dat = vq[i].dat; b_ordy = vq[i].ordy; b_fl = vq[i].fl;
                #1;
                chk($sformatf("v%0d_irdy", i), b_irdy, vq[i].e_irdy);
                chk($sformatf("v%0d_ovld", i), b_ovld, vq[i].e_ovld);
                chk($sformatf("v%0d_odat", i), b_odat, vq[i].e_odat);
                chk($sformatf("v%0d_cnt", i),  b_cnt,  vq[i].e_cnt);
                chk($sformatf("v%0d_drop", i), b_drop, vq[i].e_drop);
            end
        end

        // Simultaneous push and pop at occupancy 1 for 10 cycles
        @(negedge clk);
        idle_all();
        a_vld = 1; a_dat = 16'h100; a_ordy = 1;
        #1 chk("pp_start_cnt", a_cnt, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_dat = 16'(16'h101 + i);
            #1;
            chk($sformatf("pp%0d_odat", i), a_odat, 16'(16'h100 + i));
            chk($sformatf("pp%0d_cnt", i), a_cnt, 1);
            chk($sformatf("pp%0d_irdy", i), a_irdy, 1);
        end
        @(negedge clk);
        a_vld = 0;
        #1 chk("pp_last_odat", a_odat, 16'h10A);
        @(negedge clk);
        #1 chk("pp_empty_cnt", a_cnt, 0);

        // Asynchronous reset in mid-cycle with two entries held; drop count 3 is cleared
        @(negedge clk);
        a_vld = 1; a_dat = 16'h200; a_ordy = 0;
        @(negedge clk);
        a_dat = 16'h201;
        @(negedge clk);
        a_vld = 0;
        #1 chk("mr_pre_cnt", a_cnt, 2);
        #2 rst_n = 0;
        #1;
        chk("mr_ovld", a_ovld, 0); chk("mr_odat", a_odat, 0);
        chk("mr_cnt", a_cnt, 0);   chk("mr_irdy", a_irdy, 1);
        chk("mr_drop", a_drop, 0);
        @(negedge clk);
        rst_n = 1;

        // Drop counter saturation: each empty flush with an incoming beat adds 1
        @(negedge clk);
        a_fl = 1; a_vld = 1; a_dat = 16'h0;
        repeat (65534) @(negedge clk);
        #1 chk("sat_pre", a_drop, 16'hFFFE);
        a_fl = 0; a_vld = 1; a_dat = 16'h300; a_ordy = 0;
        @(negedge clk);
        a_dat = 16'h301;
        @(negedge clk);
        a_vld = 0; a_fl = 1;
        #1 chk("sat_cnt2", a_cnt, 2);
        @(negedge clk);
        a_fl = 0;
        #1 chk("sat_ffff", a_drop, 16'hFFFF);
        chk("sat_cnt0", a_cnt, 0);
        a_fl = 1; a_vld = 1;
        @(negedge clk);
        a_fl = 0; a_vld = 0;
        #1 chk("sat_hold", a_drop, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
